// File: rtl/mem_list_reader.sv
// mem_list_reader: walks a parameter-baked memory descriptor table and
// streams header/width/height/mask words over a valid/ready port.
// Ports: clk, reset (sync, active-high), start, busy, out_data,
//        out_valid, out_ready, out_last, done.
module mem_list_reader #(
  parameter int ENTRIES = 4,
  parameter logic [32*ENTRIES-1:0] WIDTHS  = {ENTRIES{32'd1}},
  parameter logic [32*ENTRIES-1:0] HEIGHTS = {ENTRIES{32'd1}},
  parameter logic [32*ENTRIES-1:0] MASKS   = {ENTRIES{32'd1}},
  parameter logic [7:0] TAG = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        done
);

  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [IW-1:0] LAST = IW'(ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_WID, S_HGT, S_MSK, S_FIN
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          fire;

  assign fire = out_valid && out_ready;

  function automatic logic [31:0] word_of(
    input state_t        s,
    input logic [IW-1:0] i
  );
    int k;
    k = int'(i);
    word_of = '0;
    case (s)
      S_HDR:   word_of = {TAG, 8'(i), 16'(ENTRIES)};
      S_WID:   word_of = WIDTHS[32*k +: 32];
      S_HGT:   word_of = HEIGHTS[32*k +: 32];
      S_MSK:   word_of = MASKS[32*k +: 32];
      default: word_of = '0;
    endcase
  endfunction

  // The next word is loaded together with the state change so the
  // output stays registered and back-to-back handshakes have no bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_FIN: begin
          done <= 1'b0;
          if (start) begin
            state     <= S_HDR;
            idx       <= '0;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            out_data  <= word_of(S_HDR, '0);
          end else begin
            state <= S_IDLE;
          end
        end
        S_HDR: if (fire) begin
          state    <= S_WID;
          out_data <= word_of(S_WID, idx);
        end
        S_WID: if (fire) begin
          state    <= S_HGT;
          out_data <= word_of(S_HGT, idx);
        end
        S_HGT: if (fire) begin
          state    <= S_MSK;
          out_data <= word_of(S_MSK, idx);
          out_last <= (idx == LAST);
        end
        S_MSK: if (fire) begin
          if (idx != LAST) begin
            state    <= S_HDR;
            idx      <= IW'(idx + 1'b1);
            out_data <= word_of(S_HDR, IW'(idx + 1'b1));
            out_last <= 1'b0;
          end else begin
            state     <= S_FIN;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_list_reader.md
Name: mem_list_reader

Overview:
- Runtime counterpart to the elaboration-time memory-list report. It reads a parameter-baked table of memory descriptors (width, height, mask) and streams it out as 32-bit words over a valid/ready interface.
- Sits beside the memory list. Debug/boot logic consumes the stream to discover the memory configuration at run time.
- One walk of the table per start pulse.

Parameters:
- ENTRIES, 4, number of memory descriptors in the table (1..255).
- WIDTHS, all 32'd1, packed ENTRIES x 32-bit word widths; entry i is bits [32*i +: 32].
- HEIGHTS, all 32'd1, packed ENTRIES x 32-bit word counts, same packing.
- MASKS, all 32'd1, packed ENTRIES x 32-bit write-mask granularity, same packing.
- TAG, 8'hA5, 8-bit constant placed in every header word.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a walk; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until the cycle done is pulsed.
- out_data  out  32  stream word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- out_last  out  1  qualifies the final word of a walk.
- done  out  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset values: busy=0, out_valid=0, out_last=0, done=0, out_data=0, entry index=0, FSM=IDLE. Reset takes effect on the next edge and overrides all other inputs. A reset mid-walk abandons the walk silently, with no done pulse.
- FSM states and transitions:
  - IDLE: start -> HDR (index=0).
  - HDR -> WID -> HGT -> MSK, each advancing on handshake.
  - MSK on handshake: if index < ENTRIES-1, index++ and go to HDR; else go to FIN.
  - FIN: done=1 for one cycle, then IDLE.
- Words per entry, in order:
  - HDR = {TAG, index[7:0], ENTRIES[15:0]}.
  - WID = WIDTHS[i].
  - HGT = HEIGHTS[i].
  - MSK = MASKS[i].
  - Total words per walk = 4*ENTRIES.
- Latency: start in IDLE at cycle t -> out_valid=1 with the first HDR word at t+1, and busy=1 at t+1.
- Handshake rules:
  - out_valid is registered. While out_valid && !out_ready, out_data and out_last hold stable.
  - out_valid never drops without a handshake, except on reset.
  - With out_ready held high, one word is transferred per cycle with no bubbles, including across entry boundaries.
- out_last=1 only with the MSK word of entry ENTRIES-1.
- Final handshake at cycle u: out_valid=0 at u+1, done=1 at u+1, busy=0 at u+1. A new start is accepted at u+1 or later.
- start while busy (any non-IDLE state) is ignored. It is neither queued nor counted.
- ENTRIES=1: a walk is exactly 4 words; the 4th carries out_last.
- Index width is clog2(ENTRIES) with a minimum of 1 bit. It is zero-extended into the header's 8-bit field.
- out_data is 0 whenever out_valid=0.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, start=0 -> busy=0, out_valid=0, done=0, out_data=0 for 10 cycles.
- Full-rate walk, ENTRIES=2, WIDTHS={32'd8, 32'd16}, HEIGHTS={32'd64, 32'd1024}, MASKS={32'd8, 32'd1}, out_ready=1, one-cycle start -> 8 consecutive words:
  - 32'hA500_0002, 16, 1024, 1, 32'hA501_0002, 8, 64, 8.
  - out_last only on the 8th word; done pulses the next cycle.
- Backpressure: same config, out_ready toggles 1,0,0,1,... -> each word is held stable while out_ready=0, no word is lost or duplicated, and the order matches the full-rate case.
- Start while busy: pulse start again at word 3 -> the stream is still exactly 8 words, one done pulse, busy=0 afterwards.
- Reset mid-walk: reset asserted after word 5 is accepted -> next cycle out_valid=0, busy=0, no done. A following start emits from header 32'hA500_0002.
- Single entry: ENTRIES=1, WIDTHS=32'd32, HEIGHTS=32'd256, MASKS=32'd4 -> 4 words 32'hA500_0001, 32, 256, 4, with out_last on the 4th; back-to-back start on the done cycle's successor re-emits the same 4 words.
